// File: rtl/imm_encode_loader_pkg.sv
// Shared definitions for the immediate encode/load block: immediate-type
// codes, FSM state encoding and the per-type immediate field masks.
package imm_encode_loader_pkg;

    localparam int XLEN = 32;

    // Immediate type selector; same code points as the sign-extender.
    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_e;

    // Instruction bits owned by the immediate for each type.
    localparam logic [XLEN-1:0] MASK_I = 32'hFFF0_0000;
    localparam logic [XLEN-1:0] MASK_S = 32'hFE00_0F80;
    localparam logic [XLEN-1:0] MASK_B = 32'hFE00_0F80;
    localparam logic [XLEN-1:0] MASK_J = 32'hFFFF_F000;

    function automatic logic [XLEN-1:0] imm_field_mask(input imm_src_e src);
        case (src)
            IMM_I:   return MASK_I;
            IMM_S:   return MASK_S;
            IMM_B:   return MASK_B;
            default: return MASK_J;
        endcase
    endfunction

endpackage

// File: rtl/imm_encode_loader_if.sv
// Stream-in / memory-write-out bus of the immediate encode/load block.
interface imm_encode_loader_if #(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  i_Start;
    logic [ADDR_WIDTH-1:0] i_BaseAddr;
    logic                  i_Valid;
    logic                  o_Ready;
    logic                  i_Last;
    logic [1:0]            i_ImmSrc;
    logic [BUS_WIDTH-1:0]  i_Imm;
    logic [BUS_WIDTH-1:0]  i_Skeleton;
    logic                  o_WrEn;
    logic [ADDR_WIDTH-1:0] o_WrAddr;
    logic [BUS_WIDTH-1:0]  o_WrData;
    logic                  o_Done;
    logic                  o_RangeErr;

    // Producer of the instruction stream (program loader side).
    modport master (
        output i_Start, i_BaseAddr, i_Valid, i_Last, i_ImmSrc, i_Imm, i_Skeleton,
        input  o_Ready, o_WrEn, o_WrAddr, o_WrData, o_Done, o_RangeErr
    );

    // The encode/load block itself.
    modport slave (
        input  i_Start, i_BaseAddr, i_Valid, i_Last, i_ImmSrc, i_Imm, i_Skeleton,
        output o_Ready, o_WrEn, o_WrAddr, o_WrData, o_Done, o_RangeErr
    );
endinterface

// File: rtl/imm_encode_loader_imm_encode.sv
// Combinational RV32 immediate encoder: scatters a signed immediate into the
// I/S/B/J field positions of an instruction skeleton and flags whether the
// value is representable in that format.
module imm_encode
    import imm_encode_loader_pkg::*;
(
    input  logic [1:0]             i_ImmSrc,
    input  logic signed [XLEN-1:0] i_Imm,
    input  logic [XLEN-1:0]        i_Skeleton,
    output logic [XLEN-1:0]        o_Instr,
    output logic                   o_Legal
);

    imm_src_e        src;
    logic [XLEN-1:0] field;

    assign src = imm_src_e'(i_ImmSrc);

    // Build the immediate bit pattern and range check for the selected type.
    always_comb begin
        field   = '0;
        o_Legal = 1'b0;
        case (src)
            IMM_I: begin
                field   = {i_Imm[11:0], 20'b0};
                o_Legal = (i_Imm[31:11] == {21{i_Imm[11]}});
            end
            IMM_S: begin
                field   = {i_Imm[11:5], 13'b0, i_Imm[4:0], 7'b0};
                o_Legal = (i_Imm[31:11] == {21{i_Imm[11]}});
            end
            IMM_B: begin
                field   = {i_Imm[12], i_Imm[10:5], 13'b0, i_Imm[4:1], i_Imm[11], 7'b0};
                o_Legal = !i_Imm[0] && (i_Imm[31:12] == {20{i_Imm[12]}});
            end
            default: begin
                field   = {i_Imm[20], i_Imm[10:1], i_Imm[11], i_Imm[19:12], 12'b0};
                o_Legal = !i_Imm[0] && (i_Imm[31:20] == {12{i_Imm[20]}});
            end
        endcase
        o_Instr = (i_Skeleton & ~imm_field_mask(src)) | field;
    end

endmodule

// File: rtl/imm_encode_loader.sv
// Immediate encode/load block: accepts (type, immediate, skeleton) words on
// a valid/ready stream, encodes and range-checks them, and writes the legal
// ones to instruction memory at an auto-incrementing byte address.
module imm_encode_loader
    import imm_encode_loader_pkg::*;
#(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    imm_encode_loader_if.slave bus
);

    state_e                state;
    logic                  ready_p1;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic                  wr_en_p1;
    logic [ADDR_WIDTH-1:0] wr_addr_p1;
    logic [BUS_WIDTH-1:0]  wr_data_p1;
    logic                  done_p1;
    logic                  range_err_p1;
    logic                  accept;
    logic [XLEN-1:0]       enc_instr;
    logic                  enc_legal;

    // Stage p0: combinational encode of the word currently offered.
    imm_encode u_enc (
        .i_ImmSrc   (bus.i_ImmSrc),
        .i_Imm      (bus.i_Imm),
        .i_Skeleton (bus.i_Skeleton),
        .o_Instr    (enc_instr),
        .o_Legal    (enc_legal)
    );

    assign accept = bus.i_Valid & ready_p1;

    // Sequence FSM, address counter and the p1 output register stage.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state        <= ST_IDLE;
            ready_p1     <= 1'b0;
            addr_p0      <= '0;
            wr_en_p1     <= 1'b0;
            wr_addr_p1   <= '0;
            wr_data_p1   <= '0;
            done_p1      <= 1'b0;
            range_err_p1 <= 1'b0;
        end else begin
            wr_en_p1 <= 1'b0;
            done_p1  <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (bus.i_Start) begin
                        state        <= ST_RUN;
                        ready_p1     <= 1'b1;
                        addr_p0      <= bus.i_BaseAddr & ~ADDR_WIDTH'(3);
                        range_err_p1 <= 1'b0;
                    end else if (state == ST_DONE) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (enc_legal) begin
                            wr_en_p1   <= 1'b1;
                            wr_addr_p1 <= addr_p0;
                            wr_data_p1 <= enc_instr;
                            addr_p0    <= addr_p0 + ADDR_WIDTH'(4);
                            if (bus.i_Last) begin
                                state    <= ST_DONE;
                                ready_p1 <= 1'b0;
                                done_p1  <= 1'b1;
                            end
                        end else begin
                            // Unencodable immediate: hold the address and park until restarted.
                            state        <= ST_ERR;
                            ready_p1     <= 1'b0;
                            range_err_p1 <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    ready_p1 <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_Ready    = ready_p1;
    assign bus.o_WrEn     = wr_en_p1;
    assign bus.o_WrAddr   = wr_addr_p1;
    assign bus.o_WrData   = wr_data_p1;
    assign bus.o_Done     = done_p1;
    assign bus.o_RangeErr = range_err_p1;

endmodule
